// File: rtl/raster_pkg.sv
// Shared types for the raster command path: triangle descriptor, command opcodes, scheduler states.
// Frame-buffer geometry constants live here so the rasterizer and scheduler agree on sizes.
package raster_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT;

  typedef enum logic [1:0] {
    OP_TRI   = 2'd0,
    OP_CLEAR = 2'd1,
    OP_FLIP  = 2'd2,
    OP_RSVD  = 2'd3
  } cmd_op_e;

  typedef struct packed {
    logic [8:0]  a1;
    logic [8:0]  b1;
    logic [8:0]  a2;
    logic [8:0]  b2;
    logic [8:0]  a3;
    logic [8:0]  b3;
    logic [15:0] c1;
    logic [15:0] c2;
    logic [15:0] c3;
    logic [8:0]  bbxi;
    logic [8:0]  bbxf;
    logic [7:0]  bbyi;
    logic [7:0]  bbyf;
    logic [15:0] z1;
    logic [15:0] z2;
    logic [15:0] z3;
    logic [31:0] inv_area;
    logic [7:0]  color;
  } tri_desc_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_CLEAR     = 3'd3,
    ST_FLIP_WAIT = 3'd4
  } sched_state_e;

  localparam int TRI_W = $bits(tri_desc_t);
  localparam int CMD_W = TRI_W + 2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO, registered storage, head visible combinationally the cycle after a push.
// Pushes are dropped when full and pops when empty; o_full is the backpressure signal.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_wr;
  logic             w_rd;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_dout  = r_mem[r_rptr[AW-1:0]];
  assign w_wr    = i_push & ~o_full;
  assign w_rd    = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/raster_scheduler.sv
// In-order draw command scheduler: triangle launch, buffer clear sweep, vsync-aligned flip.
// First action two cycles after accept; cmd_ready falls only when the command FIFO is full.
module raster_scheduler
  import raster_pkg::*;
#(
  parameter int         DEPTH       = 4,
  parameter int         FB_WORDS    = raster_pkg::FB_WORDS,
  parameter logic [7:0] CLEAR_COLOR = 8'h00,
  parameter logic [7:0] CLEAR_Z     = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  tri_desc_t   cmd_tri,
  output logic        rast_start,
  output tri_desc_t   rast_tri,
  input  logic        rast_done,
  output logic        clr_we,
  output logic [16:0] clr_addr,
  output logic [7:0]  fb_clr_data,
  output logic [7:0]  zb_clr_data,
  input  logic        vsync,
  output logic        front_sel,
  output logic        busy,
  output logic [15:0] tri_count
);

  sched_state_e     r_state;
  sched_state_e     w_state_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CMD_W-1:0] w_fifo_dout;
  cmd_op_e          w_head_op;
  tri_desc_t        w_head_tri;
  logic [16:0]      r_clr_addr;
  tri_desc_t        r_rast_tri;
  logic [15:0]      r_tri_count;
  logic             r_front_sel;
  logic             r_vsync_q;
  logic             w_vsync_rise;
  logic             w_clr_last;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   ({cmd_op, cmd_tri}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_push       = cmd_valid & ~w_full;
  assign w_pop        = (r_state == ST_IDLE) & ~w_empty;
  assign w_head_op    = cmd_op_e'(w_fifo_dout[CMD_W-1 -: 2]);
  assign w_head_tri   = w_fifo_dout[TRI_W-1:0];
  assign w_vsync_rise = vsync & ~r_vsync_q;
  assign w_clr_last   = (r_clr_addr == 17'(FB_WORDS - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          case (w_head_op)
            OP_TRI:   w_state_nxt = ST_LAUNCH;
            OP_CLEAR: w_state_nxt = ST_CLEAR;
            OP_FLIP:  w_state_nxt = ST_FLIP_WAIT;
            default:  w_state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_LAUNCH:    w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (rast_done) w_state_nxt = ST_IDLE;
      ST_CLEAR:     if (w_clr_last) w_state_nxt = ST_IDLE;
      ST_FLIP_WAIT: if (w_vsync_rise) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_addr  <= '0;
      r_rast_tri  <= '0;
      r_tri_count <= '0;
      r_front_sel <= 1'b0;
      r_vsync_q   <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
      if (w_pop && (w_head_op == OP_TRI)) begin
        r_rast_tri <= w_head_tri;
      end
      if (w_pop && (w_head_op == OP_CLEAR)) begin
        r_clr_addr <= '0;
      end else if (r_state == ST_CLEAR) begin
        r_clr_addr <= w_clr_last ? 17'd0 : r_clr_addr + 17'd1;
      end
      if ((r_state == ST_WAIT_DONE) && rast_done) begin
        r_tri_count <= sat_inc16(r_tri_count);
      end
      // Only an edge seen while already waiting may flip; earlier edges are history.
      if ((r_state == ST_FLIP_WAIT) && w_vsync_rise) begin
        r_front_sel <= ~r_front_sel;
        r_tri_count <= '0;
      end
    end
  end

  assign cmd_ready   = ~w_full;
  assign rast_start  = (r_state == ST_LAUNCH);
  assign rast_tri    = r_rast_tri;
  assign clr_we      = (r_state == ST_CLEAR);
  assign clr_addr    = r_clr_addr;
  assign fb_clr_data = CLEAR_COLOR;
  assign zb_clr_data = CLEAR_Z;
  assign front_sel   = r_front_sel;
  assign busy        = (r_state != ST_IDLE) | ~w_empty;
  assign tri_count   = r_tri_count;

endmodule

// File: tb/tb_raster_scheduler.sv
// Bench for raster_scheduler: queue-based command model checked every cycle, plus directed literal checks.
module tb_raster_scheduler;
  import raster_pkg::*;

  localparam int DEPTH = 4;
  localparam int FBW   = 16;

  localparam int J_NONE  = 0;
  localparam int J_START = 1;
  localparam int J_WAIT  = 2;
  localparam int J_CLEAR = 3;
  localparam int J_FLIP  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  tri_desc_t   cmd_tri = '0;
  logic        rast_start;
  tri_desc_t   rast_tri;
  logic        rast_done;
  logic        auto_done = 1'b0;
  logic        spur_done = 1'b0;
  logic        clr_we;
  logic [16:0] clr_addr;
  logic [7:0]  fb_clr_data;
  logic [7:0]  zb_clr_data;
  logic        vsync = 1'b0;
  logic        front_sel;
  logic        busy;
  logic [15:0] tri_count;

  assign rast_done = auto_done | spur_done;

  always #5 clk = ~clk;

  raster_scheduler #(
    .DEPTH       (DEPTH),
    .FB_WORDS    (FBW),
    .CLEAR_COLOR (8'h00),
    .CLEAR_Z     (8'hFF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_tri     (cmd_tri),
    .rast_start  (rast_start),
    .rast_tri    (rast_tri),
    .rast_done   (rast_done),
    .clr_we      (clr_we),
    .clr_addr    (clr_addr),
    .fb_clr_data (fb_clr_data),
    .zb_clr_data (zb_clr_data),
    .vsync       (vsync),
    .front_sel   (front_sel),
    .busy        (busy),
    .tri_count   (tri_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: pending command queue plus the job currently being carried out.
  typedef struct packed {
    logic [1:0] op;
    tri_desc_t  t;
  } cmd_t;

  cmd_t        mq[$];
  int          m_job = J_NONE;
  int          m_idx = 0;
  logic [15:0] m_cnt = '0;
  logic        m_fsel = 1'b0;
  logic        m_vprev = 1'b0;
  tri_desc_t   m_tri = '0;

  always @(posedge clk or negedge rst_n) begin
    cmd_t in_c;
    cmd_t h;
    bit   do_push;
    if (!rst_n) begin
      mq.delete();
      m_job   = J_NONE;
      m_idx   = 0;
      m_cnt   = '0;
      m_fsel  = 1'b0;
      m_vprev = 1'b0;
      m_tri   = '0;
    end else begin
      in_c.op = cmd_op;
      in_c.t  = cmd_tri;
      do_push = cmd_valid && (mq.size() < DEPTH);
      case (m_job)
        J_NONE: begin
          if (mq.size() > 0) begin
            h = mq.pop_front();
            if (h.op == 2'd0) begin
              m_tri = h.t;
              m_job = J_START;
            end else if (h.op == 2'd1) begin
              m_job = J_CLEAR;
              m_idx = 0;
            end else if (h.op == 2'd2) begin
              m_job = J_FLIP;
            end
          end
        end
        J_START: m_job = J_WAIT;
        J_WAIT: begin
          if (rast_done) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_job = J_NONE;
          end
        end
        J_CLEAR: begin
          if (m_idx == FBW - 1) begin
            m_idx = 0;
            m_job = J_NONE;
          end else begin
            m_idx = m_idx + 1;
          end
        end
        J_FLIP: begin
          if (vsync && !m_vprev) begin
            m_fsel = !m_fsel;
            m_cnt  = '0;
            m_job  = J_NONE;
          end
        end
        default: m_job = J_NONE;
      endcase
      m_vprev = vsync;
      if (do_push) mq.push_back(in_c);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
      chk("rast_start", rast_start, m_job == J_START);
      chk("rast_tri", rast_tri, m_tri);
      chk("clr_we", clr_we, m_job == J_CLEAR);
      chk("clr_addr", clr_addr, 17'(m_idx));
      chk("fb_clr_data", fb_clr_data, 8'h00);
      chk("zb_clr_data", zb_clr_data, 8'hFF);
      chk("tri_count", tri_count, m_cnt);
      chk("front_sel", front_sel, m_fsel);
      chk("busy", busy, (m_job != J_NONE) || (mq.size() > 0));
    end
  end

  // Rasterizer stand-in: done pulse lat cycles after each observed start.
  int lat = 10;
  int dcnt = 0;
  bit dact = 0;
  int n_start = 0;
  int n_we = 0;

  always begin
    @(posedge clk);
    #2;
    if (!rst_n) begin
      dact      = 0;
      auto_done = 1'b0;
    end else begin
      auto_done = 1'b0;
      if (dact) begin
        dcnt = dcnt - 1;
        if (dcnt == 0) begin
          auto_done = 1'b1;
          dact      = 0;
        end
      end
      if (rast_start) begin
        dact    = 1;
        dcnt    = lat;
        n_start = n_start + 1;
      end
      if (clr_we) n_we = n_we + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    spur_done = 1'b0;
    vsync     = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [1:0] op, input tri_desc_t t);
    int n = 0;
    cmd_op    = op;
    cmd_tri   = t;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push_timeout", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (rast_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk(nm, rast_start, 1'b1);
  endtask

  function automatic tri_desc_t rnd_tri(input logic [7:0] col);
    logic [223:0] v;
    for (int i = 0; i < 7; i++) v[i*32 +: 32] = $urandom();
    v[7:0] = col;
    return tri_desc_t'(v);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tri_desc_t t;
    int        s0;
    int        w0;
    int        n;

    // Reset state
    do_reset();
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rast_start", rast_start, 1'b0);
    chk("rst_clr_we", clr_we, 1'b0);
    chk("rst_clr_addr", clr_addr, 17'd0);
    chk("rst_rast_tri", rast_tri, 224'd0);
    chk("rst_tri_count", tri_count, 16'd0);
    chk("rst_front_sel", front_sel, 1'b0);
    chk("rst_zb", zb_clr_data, 8'hFF);
    chk("rst_fb", fb_clr_data, 8'h00);

    // Single triangle: start at k+2, done 10 cycles later
    lat = 10;
    t = rnd_tri(8'h5A);
    push(2'd0, t);
    chk("t1_start_k1", rast_start, 1'b0);
    tick(1);
    chk("t1_start_k2", rast_start, 1'b1);
    chk("t1_tri", rast_tri, t);
    chk("t1_color", rast_tri.color, 8'h5A);
    tick(1);
    chk("t1_start_pulse", rast_start, 1'b0);
    tick(8);
    chk("t1_busy_before_done", busy, 1'b1);
    tick(1);
    tick(1);
    chk("t1_count", tri_count, 16'd1);
    chk("t1_busy_after", busy, 1'b0);

    // Five back-to-back triangles into a 4-deep FIFO
    do_reset();
    lat = 6;
    for (int i = 1; i <= 5; i++) push(2'd0, rnd_tri(8'(i)));
    chk("t2_full_ready", cmd_ready, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      wait_done("t2_done_timeout");
      tick(1);
      chk("t2_start_d1", rast_start, 1'b0);
      tick(1);
      chk("t2_start_d2", rast_start, 1'b1);
      chk("t2_order", rast_tri.color, 8'(i));
    end
    wait_done("t2_last_done_timeout");
    tick(1);
    chk("t2_count", tri_count, 16'd5);

    // Clear sweep
    push(2'd1, '0);
    tick(1);
    for (int i = 0; i < FBW; i++) begin
      chk("t3_we", clr_we, 1'b1);
      chk("t3_addr", clr_addr, 17'(i));
      tick(1);
    end
    chk("t3_we_off", clr_we, 1'b0);
    chk("t3_addr_zero", clr_addr, 17'd0);
    chk("t3_idle", busy, 1'b0);
    chk("t3_count_kept", tri_count, 16'd5);

    // Flip while vsync already high
    vsync = 1'b1;
    tick(3);
    push(2'd2, '0);
    tick(5);
    chk("t4_hold_high", front_sel, 1'b0);
    chk("t4_busy", busy, 1'b1);
    vsync = 1'b0;
    tick(3);
    chk("t4_hold_low", front_sel, 1'b0);
    vsync = 1'b1;
    tick(1);
    chk("t4_toggled", front_sel, 1'b1);
    chk("t4_count_zero", tri_count, 16'd0);
    chk("t4_idle", busy, 1'b0);

    // Spurious done pulses and reserved op
    lat = 4;
    push(2'd0, rnd_tri(8'h11));
    tick(10);
    chk("t5_count1", tri_count, 16'd1);
    spur_done = 1'b1;
    tick(1);
    spur_done = 1'b0;
    tick(1);
    chk("t5_idle_spur", tri_count, 16'd1);
    s0 = n_start;
    w0 = n_we;
    push(2'd3, rnd_tri(8'h22));
    tick(5);
    chk("t5_rsvd_start", n_start - s0, 0);
    chk("t5_rsvd_we", n_we - w0, 0);
    chk("t5_rsvd_idle", busy, 1'b0);
    push(2'd1, '0);
    tick(3);
    chk("t5_in_clear", clr_we, 1'b1);
    spur_done = 1'b1;
    tick(1);
    spur_done = 1'b0;
    tick(20);
    chk("t5_clear_spur", tri_count, 16'd1);

    // Reset in the middle of a clear with a triangle queued
    push(2'd1, '0);
    push(2'd0, rnd_tri(8'h33));
    n = 0;
    while (clr_addr !== 17'd7 && n < 100) begin
      tick(1);
      n++;
    end
    chk("t6_reach_addr7", clr_addr, 17'd7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_we_drop", clr_we, 1'b0);
    chk("t6_start_drop", rast_start, 1'b0);
    s0 = n_start;
    tick(2);
    rst_n = 1'b1;
    chk("t6_ready", cmd_ready, 1'b1);
    chk("t6_busy", busy, 1'b0);
    chk("t6_front_sel", front_sel, 1'b0);
    tick(20);
    chk("t6_tri_discarded", n_start - s0, 0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      n = $urandom_range(0, 9);
      cmd_op    = (n < 6) ? 2'd0 : (n < 7) ? 2'd1 : (n < 9) ? 2'd2 : 2'd3;
      cmd_tri   = rnd_tri(8'($urandom()));
      lat       = $urandom_range(1, 8);
      spur_done = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 5) == 0) vsync = ~vsync;
      tick(1);
    end
    cmd_valid = 1'b0;
    spur_done = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      if ($urandom_range(0, 3) == 0) vsync = ~vsync;
      tick(1);
      n++;
    end
    chk("rand_drain", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/raster_scheduler.md
# raster_scheduler

Command scheduler in front of the triangle rasterizer. Accepts draw commands from the MicroBlaze command path into a small FIFO and executes them in order:
- triangle commands: load a descriptor, pulse the rasterizer start, wait for its done;
- clear commands: sweep the frame buffer and z-buffer to their clear values;
- flip commands: swap front/back frame buffers on the next vsync.

It is the only block that drives rasterizer start and the buffer-clear write port.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- FB_WORDS, 76800: pixels per buffer (320×240).
- CLEAR_COLOR, 8'h00: frame-buffer clear value.
- CLEAR_Z, 8'hFF: z-buffer clear value (farthest depth).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  system clock.
  - rst_n  in  1  asynchronous active-low reset.
- Command input:
  - cmd_valid  in  1  command offered.
  - cmd_ready  out  1  FIFO not full.
  - cmd_op  in  2  0 = TRI, 1 = CLEAR, 2 = FLIP, 3 = reserved.
  - cmd_tri  in  tri_desc_t (224 bits)  triangle descriptor; ignored unless op = TRI.
- Rasterizer:
  - rast_start  out  1  single-cycle start pulse.
  - rast_tri  out  tri_desc_t  registered descriptor; stable from start until done.
  - rast_done  in  1  rasterizer completion pulse.
- Buffer clear:
  - clr_we  out  1  clear-write strobe to frame buffer and z-buffer.
  - clr_addr  out  17  clear address.
  - fb_clr_data  out  8  CLEAR_COLOR.
  - zb_clr_data  out  8  CLEAR_Z.
- Display:
  - vsync  in  1  vsync level, synchronous to clk.
  - front_sel  out  1  buffer currently displayed; the back buffer is ~front_sel.
- Status:
  - busy  out  1  FSM not IDLE or FIFO non-empty.
  - tri_count  out  16  triangles completed since the last flip; saturates at 16'hFFFF.

## Operation
- Command accept:
  - Handshake is cmd_valid & cmd_ready; on handshake, {cmd_op, cmd_tri} is pushed.
  - cmd_ready = !full.
  - A push and a pop in the same cycle are legal when the FIFO is not full.
- FSM states: IDLE, LAUNCH, WAIT_DONE, CLEAR, FLIP_WAIT.
- IDLE: if the FIFO is non-empty, pop the head and dispatch on its op:
  - TRI → capture rast_tri, go to LAUNCH.
  - CLEAR → clr_addr = 0, go to CLEAR.
  - FLIP → go to FLIP_WAIT.
  - reserved → discard, stay in IDLE.
- LAUNCH: rast_start = 1 for exactly this cycle; go to WAIT_DONE.
- WAIT_DONE: on rast_done, tri_count++ (saturating) and go to IDLE.
  - rast_done in any other state is ignored.
- CLEAR: clr_we = 1 every cycle; clr_addr increments by 1 each cycle.
  - In the cycle clr_addr = FB_WORDS-1, the write occurs and the next state is IDLE.
  - clr_addr returns to 0.
- FLIP_WAIT: vsync_q registers vsync every cycle in all states.
  - A rising edge (vsync & !vsync_q) while in FLIP_WAIT toggles front_sel, zeroes tri_count and goes to IDLE.
  - An edge that occurred before entering FLIP_WAIT does not count.
  - If vsync is already high on entry, wait for the next rising edge.
- fb_clr_data and zb_clr_data are constant outputs.

## Timing
- Reset values:
  - All outputs 0 except zb_clr_data = CLEAR_Z and fb_clr_data = CLEAR_COLOR.
  - cmd_ready = 1 out of reset, since the FIFO is empty.
  - State is IDLE, FIFO pointers are 0, vsync_q = 0, rast_tri = 0.
- Latency, with handshake in cycle k:
  - Entry is visible in the FIFO in cycle k+1, and IDLE pops it in k+1.
  - The first action occurs in cycle k+2: rast_start, or clr_we with addr 0, or entry to FLIP_WAIT.
- Triangle throughput: rast_done in cycle d → IDLE in d+1 → next rast_start in d+2.
- CLEAR occupancy: exactly FB_WORDS cycles of clr_we = 1, followed by IDLE.
- Reset mid-operation: async assertion immediately drops rast_start and clr_we and flushes the FIFO. The rasterizer shares rst_n.

## Structure
- Package raster_pkg:
  - tri_desc_t packed struct: a1, b1, a2, b2, a3, b3 [8:0]; c1, c2, c3 [15:0]; bbxi, bbxf [8:0]; bbyi, bbyf [7:0]; z1, z2, z3 [15:0]; inv_area [31:0]; color [7:0].
  - cmd_op_e enum.
  - Constants FB_WIDTH = 320, FB_HEIGHT = 240, FB_WORDS.
  - rasterizer consumes the same tri_desc_t.
- Sub-module cmd_fifo:
  - Parameterized synchronous FIFO (WIDTH, DEPTH).
  - Registered storage, full/empty via pointers with an extra wrap bit.

## Test plan
- Reset then single TRI (color 8'h5A):
  - rast_start high exactly 1 cycle at k+2, with rast_tri = the descriptor.
  - Rasterizer model returns done 10 cycles later → tri_count = 1, busy low 1 cycle after done.
- Push 5 TRIs back-to-back with DEPTH = 4 while the first is executing:
  - cmd_ready drops when 4 entries are held.
  - All 5 are launched in order; each start occurs at done+2.
  - tri_count = 5.
- CLEAR with FB_WORDS = 16:
  - clr_we high 16 consecutive cycles with addr 0..15, fb data 8'h00 and z data 8'hFF.
  - Then IDLE, and clr_addr returns to 0.
- FLIP issued while vsync is high:
  - front_sel is unchanged until vsync falls and rises again.
  - Then front_sel toggles and tri_count = 0.
- Spurious rast_done in IDLE and in CLEAR, plus a reserved op (3):
  - tri_count unchanged; the reserved op is consumed with no rast_start or clr_we.
- Assert rst_n in the middle of CLEAR at addr 7:
  - clr_we drops immediately and the queued TRI is discarded.
  - After release: cmd_ready = 1, busy = 0, front_sel = 0.
